// File: rtl/sub_bytes_sched_pkg.sv
// sub_bytes_sched_pkg: FSM encoding, chunking helpers and the AES forward S-box table
// shared by the time-multiplexed SubBytes engine.
package sub_bytes_sched_pkg;

    localparam int STATE_BYTES = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic int num_chunks(int lanes);
        return STATE_BYTES / lanes;
    endfunction

    function automatic bit lanes_legal(int lanes);
        return lanes == 4 || lanes == 8 || lanes == 16;
    endfunction

    // Entry 0x00 sits in the most significant byte.
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(logic [7:0] x);
        return SBOX_TAB[8*(255-int'(x)) +: 8];
    endfunction

endpackage

// File: rtl/sub_bytes_sched_if.sv
// sub_bytes_sched_if: state stream in/out plus the key-expansion SubWord request port.
interface sub_bytes_sched_if;
    logic         s_valid;
    logic         s_ready;
    logic [127:0] s_data;
    logic         s_enable;
    logic         m_valid;
    logic         m_ready;
    logic [127:0] m_data;
    logic         kw_req;
    logic [31:0]  kw_word;
    logic         kw_gnt;
    logic         kw_done;
    logic [31:0]  kw_result;

    modport master (
        output s_valid, s_data, s_enable, m_ready, kw_req, kw_word,
        input  s_ready, m_valid, m_data, kw_gnt, kw_done, kw_result
    );

    modport slave (
        input  s_valid, s_data, s_enable, m_ready, kw_req, kw_word,
        output s_ready, m_valid, m_data, kw_gnt, kw_done, kw_result
    );
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: single-byte AES forward S-box lookup.
module aes_sbox
    import sub_bytes_sched_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    assign y_o = sbox(a_i);
endmodule

// File: rtl/sub_bytes_sched_lane_bank.sv
// sbox_lane_bank: LANES parallel S-boxes, purely combinational, byte i on bits [8*i +: 8].
module sbox_lane_bank #(
    parameter int LANES = 4
) (
    input  logic [8*LANES-1:0] a_i,
    output logic [8*LANES-1:0] y_o
);
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        aes_sbox u_sbox (.a_i(a_i[8*i +: 8]), .y_o(y_o[8*i +: 8]));
    end
endmodule

// File: rtl/sub_bytes_sched.sv
// sub_bytes_sched: SubBytes over a narrow S-box bank, LANES bytes per cycle, sharing the
// bank with key-expansion SubWord requests under alternating priority while busy.
module sub_bytes_sched
    import sub_bytes_sched_pkg::*;
#(
    parameter int LANES = 4
) (
    input logic              clk,
    input logic              rst,
    sub_bytes_sched_if.slave bus
);
    localparam int LW  = 8 * LANES;
    localparam int NCH = num_chunks(LANES);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("sub_bytes_sched: LANES must be 4, 8 or 16");
    end

    logic [1:0]    state_q, state_d;
    logic [1:0]    chunk_q, chunk_d;
    logic          kw_last_q, kw_last_d;
    logic          kw_done_q;
    logic [31:0]   kw_result_q, kw_result_d;
    logic [127:0]  work_q, work_d;
    logic [127:0]  m_data_q, m_data_d;
    logic [127:0]  merged;
    logic [LW-1:0] bank_in, bank_out;
    logic          serve, last;

    assign bus.s_ready   = !rst && state_q == IDLE;
    assign bus.kw_gnt    = !rst && bus.kw_req && !(state_q == BUSY && kw_last_q);
    assign bus.m_valid   = state_q == DONE;
    assign bus.m_data    = m_data_q;
    assign bus.kw_done   = kw_done_q;
    assign bus.kw_result = kw_result_q;

    // A granted key word pre-empts the state chunk for this cycle; the chunk counter holds.
    assign serve   = state_q == BUSY && !bus.kw_gnt;
    assign last    = chunk_q == 2'(NCH - 1);
    assign bank_in = bus.kw_gnt ? LW'(bus.kw_word) : work_q[LW*chunk_q +: LW];

    sbox_lane_bank #(.LANES(LANES)) u_bank (.a_i(bank_in), .y_o(bank_out));

    always_comb begin
        merged = work_q;
        merged[LW*chunk_q +: LW] = bank_out;
    end

    always_comb begin
        state_d  = state_q;
        chunk_d  = chunk_q;
        work_d   = work_q;
        m_data_d = m_data_q;
        if (state_q == IDLE && bus.s_valid) begin
            state_d  = bus.s_enable ? BUSY : DONE;
            chunk_d  = '0;
            work_d   = bus.s_data;
            m_data_d = bus.s_enable ? m_data_q : bus.s_data;
        end else if (serve) begin
            work_d   = merged;
            chunk_d  = chunk_q + 2'd1;
            state_d  = last ? DONE : BUSY;
            m_data_d = last ? merged : m_data_q;
        end else if (state_q == DONE && bus.m_ready) begin
            state_d = IDLE;
        end
    end

    assign kw_last_d   = state_q == BUSY && bus.kw_gnt;
    assign kw_result_d = bus.kw_gnt ? bank_out[31:0] : kw_result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            chunk_q     <= '0;
            kw_last_q   <= 1'b0;
            kw_done_q   <= 1'b0;
            kw_result_q <= '0;
            work_q      <= '0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            chunk_q     <= chunk_d;
            kw_last_q   <= kw_last_d;
            kw_done_q   <= bus.kw_gnt;
            kw_result_q <= kw_result_d;
            work_q      <= work_d;
            m_data_q    <= m_data_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_sched.sv
// tb_sub_bytes_sched: directed and randomized checks of sub_bytes_sched against a
// GF(2^8)-derived S-box and a transaction-level arbitration model.
module tb_sub_bytes_sched;

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] PT_IN    = 128'h0123456789abcdeffedcba9876543210;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sub_bytes_sched_if a ();
    sub_bytes_sched_if b ();

    sub_bytes_sched #(.LANES(4))  u4  (.clk(clk), .rst(rst), .bus(a.slave));
    sub_bytes_sched #(.LANES(16)) u16 (.clk(clk), .rst(rst), .bus(b.slave));

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] sb [256];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(logic [7:0] x, logic [7:0] y);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(logic [7:0] x);
        logic [7:0] s = 8'h00;
        for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) s = 8'(y);
        return s ^ {s[6:0], s[7]} ^ {s[5:0], s[7:6]} ^ {s[4:0], s[7:5]} ^ {s[3:0], s[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_ref(logic [127:0] d, int nbytes);
        for (int i = 0; i < nbytes; i++) d[8*i +: 8] = sb[d[8*i +: 8]];
        return d;
    endfunction

    // Accept one state on the LANES=4 instance and wait (bounded) for its result.
    task automatic xfer_a(input logic [127:0] d, input logic en, input logic kw,
                          output int lat, output int g);
        logic pg = 1'b0;
        @(negedge clk);
        a.s_valid = 1'b1; a.s_data = d; a.s_enable = en; a.m_ready = 1'b0;
        #1 check("accept_ready", a.s_ready, 1'b1);
        @(negedge clk);
        a.s_valid = 1'b0; a.kw_req = kw; lat = 1; g = 0;
        #1;
        while (!a.m_valid && lat < 40) begin
            if (kw) begin
                check("kw_alternate", a.kw_gnt, lat[0]);
                check("kw_done_pulse", a.kw_done, pg);
                if (a.kw_done) check("kw_result", a.kw_result, sub_ref({96'h0, a.kw_word}, 4));
                pg = a.kw_gnt;
                g += int'(a.kw_gnt);
            end
            @(negedge clk);
            lat++;
            #1;
        end
        a.kw_req = 1'b0;
    endtask

    task automatic release_a();
        @(negedge clk);
        a.m_ready = 1'b1;
        #1 check("no_same_cycle_accept", a.s_ready, 1'b0);
        @(negedge clk);
        a.m_ready = 1'b0;
        #1 check("ready_after_release", a.s_ready, 1'b1);
        check("valid_after_release", a.m_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, g, ph, served;
        logic prev_g, pend, eg;
        logic [127:0] exp_d;
        logic [31:0] exp_kw;
        for (int i = 0; i < 256; i++) sb[i] = ref_sbox(8'(i));
        a.s_valid = 0; a.s_data = '0; a.s_enable = 0; a.m_ready = 0; a.kw_req = 1; a.kw_word = '0;
        b.s_valid = 0; b.s_data = '0; b.s_enable = 0; b.m_ready = 0; b.kw_req = 0; b.kw_word = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_s_ready", a.s_ready, 1'b0);
        check("rst_kw_gnt", a.kw_gnt, 1'b0);
        check("rst_m_valid", a.m_valid, 1'b0);
        check("rst_m_data", a.m_data, 128'h0);
        check("rst_kw_done", a.kw_done, 1'b0);
        check("rst_kw_result", a.kw_result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("ready_after_rst", a.s_ready, 1'b1);
        check("idle_kw_gnt", a.kw_gnt, 1'b1);
        a.kw_req = 1'b0;

        xfer_a(FIPS_IN, 1'b1, 1'b0, lat, g);
        check("fips_latency", lat, 5);
        check("fips_data", a.m_data, FIPS_OUT);
        check("fips_model", a.m_data, sub_ref(FIPS_IN, 16));
        release_a();

        a.kw_word = 32'h00000053;
        xfer_a(FIPS_IN, 1'b1, 1'b1, lat, g);
        check("kw_grants", g, 4);
        check("kw_latency", lat, 5 + g);
        check("kw_fips_data", a.m_data, FIPS_OUT);
        check("kw_result_const", a.kw_result, 32'h636363ed);
        release_a();

        xfer_a(PT_IN, 1'b0, 1'b0, lat, g);
        check("pt_latency", lat, 1);
        check("pt_data", a.m_data, PT_IN);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 check("bp_data", a.m_data, PT_IN);
            check("bp_s_ready", a.s_ready, 1'b0);
            check("bp_m_valid", a.m_valid, 1'b1);
        end
        release_a();

        @(negedge clk);
        a.s_valid = 1'b1; a.s_data = FIPS_IN; a.s_enable = 1'b1;
        @(negedge clk);
        a.s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_m_valid", a.m_valid, 1'b0);
        check("midrst_m_data", a.m_data, 128'h0);
        check("midrst_kw_result", a.kw_result, 32'h0);
        check("midrst_kw_done", a.kw_done, 1'b0);
        check("midrst_s_ready", a.s_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1 check("midrst_no_valid", a.m_valid, 1'b0);
        end
        xfer_a(128'h0, 1'b1, 1'b0, lat, g);
        check("zero_latency", lat, 5);
        check("zero_data", a.m_data, {16{8'h63}});
        release_a();

        @(negedge clk);
        b.s_valid = 1'b1; b.s_data = FIPS_IN; b.s_enable = 1'b1;
        @(negedge clk);
        b.s_valid = 1'b0; lat = 1;
        #1;
        while (!b.m_valid && lat < 40) begin
            @(negedge clk);
            lat++;
            #1;
        end
        check("l16_latency", lat, 2);
        check("l16_data", b.m_data, FIPS_OUT);
        b.m_ready = 1'b1;
        @(negedge clk);
        b.m_ready = 1'b0;
        g = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            b.kw_req = 1'b1; b.kw_word = 32'h01010101;
            #1 check("idle_gnt", b.kw_gnt, 1'b1);
            g += int'(b.kw_gnt);
            if (i > 0) check("idle_kw_done", b.kw_done, 1'b1);
        end
        @(negedge clk);
        b.kw_req = 1'b0;
        #1 check("idle_grants", g, 3);
        check("idle_kw_done_last", b.kw_done, 1'b1);
        check("idle_kw_result", b.kw_result, 32'h7c7c7c7c);

        ph = 0; served = 0; prev_g = 1'b0; pend = 1'b0; exp_kw = 32'h0; exp_d = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            a.s_valid  = 1'($urandom_range(0, 1));
            a.s_enable = $urandom_range(0, 3) != 0;
            a.s_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            a.kw_req   = 1'($urandom_range(0, 1));
            a.kw_word  = $urandom();
            a.m_ready  = $urandom_range(0, 2) == 0;
            #1;
            eg = a.kw_req && !(ph == 1 && prev_g);
            check("r_kw_done", a.kw_done, pend);
            check("r_kw_result", a.kw_result, exp_kw);
            check("r_kw_gnt", a.kw_gnt, eg);
            check("r_s_ready", a.s_ready, ph == 0);
            check("r_m_valid", a.m_valid, ph == 2);
            if (ph == 2) check("r_m_data", a.m_data, exp_d);
            pend = eg;
            if (eg) exp_kw = 32'(sub_ref({96'h0, a.kw_word}, 4));
            if (ph == 0) begin
                if (a.s_valid) begin
                    exp_d  = a.s_enable ? sub_ref(a.s_data, 16) : a.s_data;
                    ph     = a.s_enable ? 1 : 2;
                    served = 0;
                    prev_g = 1'b0;
                end
            end else if (ph == 1) begin
                if (eg) prev_g = 1'b1;
                else begin
                    prev_g = 1'b0;
                    served++;
                    if (served == 4) ph = 2;
                end
            end else if (a.m_ready) begin
                ph = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
